pipe_ctrl_sv: RTL and testbench

Valid/ready control unit that drives the `we`/`clr` pins of an S-stage chain of data pipeline registers. It tracks a valid bit per stage, applies backpressure from the consumer, collapses bubbles and executes synchronous flushes. It sits beside the datapath of the pipelined adder. It owns the upstream handshake (`in_valid`/`in_ready`) and the downstream handshake (`out_valid`/`out_ready`). The datapath registers only follow its enables.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_ctrl_stage_sv.sv | 29 ++
 rtl/pipe_ctrl_sv.sv | 79 +++++++
 tb/tb_pipe_ctrl_sv.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and sizing helpers for the pipeline control slice
package pipe_pkg;

  localparam int S_DEFAULT = 3;

  // Occupancy must represent 0..S inclusive.
  function automatic int occ_width(input int stages);
    return $clog2(stages + 1);
  endfunction

  typedef struct packed {
    logic valid;
    logic ready;
  } handshake_t;

endpackage

// File: rtl/pipe_ctrl_stage_sv.sv
// rtl/pipe_ctrl_stage_sv.sv - one stage of the valid chain: valid bit, advance, write enable and clear
module pipe_ctrl_stage_sv (
  input  logic clk,
  input  logic resetn,
  input  logic flush,
  input  logic src,
  input  logic adv_next,
  output logic valid,
  output logic adv,
  output logic we,
  output logic clr
);

  // An empty stage always accepts, which is what collapses bubbles.
  assign adv = !valid | adv_next;
  assign we  = flush | adv;
  assign clr = flush | (adv & !src);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (adv) begin
      valid <= src;
    end
  end

endmodule

// File: rtl/pipe_ctrl_sv.sv
// rtl/pipe_ctrl_sv.sv - valid/ready control for an S-stage register chain with backpressure and flush
module pipe_ctrl_sv
  import pipe_pkg::*;
#(
  parameter int S  = S_DEFAULT,
  parameter int CW = occ_width(S)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [S-1:0]  we,
  output logic [S-1:0]  clr,
  output logic [CW-1:0] occ,
  output logic          busy
);

  logic [S-1:0] v;
  logic [S-1:0] src;
  handshake_t   up;
  handshake_t   dn;
  logic         accept;
  logic         deliver;

  assign src[0] = in_valid;
  for (genvar i = 1; i < S; i++) begin : g_src
    assign src[i] = v[i-1];
  end

  // Advance ripples from the output end back toward stage 0.
  for (genvar i = 0; i < S; i++) begin : g_stage
    logic adv_here;
    logic adv_next;

    if (i == S - 1) begin : g_last
      assign adv_next = out_ready;
    end else begin : g_mid
      assign adv_next = g_stage[i+1].adv_here;
    end

    pipe_ctrl_stage_sv u_stage (
      .clk      (clk),
      .resetn   (resetn),
      .flush    (flush),
      .src      (src[i]),
      .adv_next (adv_next),
      .valid    (v[i]),
      .adv      (adv_here),
      .we       (we[i]),
      .clr      (clr[i])
    );
  end

  assign in_ready  = g_stage[0].adv_here & !flush;
  assign out_valid = v[S-1] & !flush;

  assign up      = '{valid: in_valid,  ready: in_ready};
  assign dn      = '{valid: out_valid, ready: out_ready};
  assign accept  = up.valid & up.ready;
  assign deliver = dn.valid & dn.ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      occ <= '0;
    end else if (flush) begin
      occ <= '0;
    end else if (accept && !deliver) begin
      occ <= occ + CW'(1);
    end else if (!accept && deliver) begin
      occ <= occ - CW'(1);
    end
  end

  assign busy = (occ != '0);

endmodule

// File: tb/tb_pipe_ctrl_sv.sv
// tb/tb_pipe_ctrl_sv.sv - directed self-checking bench for pipe_ctrl_sv with S=3
module tb_pipe_ctrl_sv;

  logic       clk;
  logic       resetn;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] we;
  logic [2:0] clr;
  logic [1:0] occ;
  logic       busy;

  logic [7:0] in_data;
  logic [7:0] d0, d1, d2;

  int tests = 0;
  int fails = 0;

  pipe_ctrl_sv #(.S(3), .CW(2)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .we        (we),
    .clr       (clr),
    .occ       (occ),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Datapath registers that only follow the controller's we/clr.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      d0 <= 8'd0;
      d1 <= 8'd0;
      d2 <= 8'd0;
    end else begin
      if (we[0]) d0 <= clr[0] ? 8'd0 : in_data;
      if (we[1]) d1 <= clr[1] ? 8'd0 : d0;
      if (we[2]) d2 <= clr[2] ? 8'd0 : d1;
    end
  end

  task automatic drain();
    bit done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      flush = 1'b0;
      #1;
      if (occ == 2'd0) done = 1'b1;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL drain_timeout occ=%0d required 0", occ);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    tests++;
    if (occ !== 2'd0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_state occ=%0d busy=%b out_valid=%b required 0 0 0", occ, busy, out_valid);
    end
    tests++;
    if (in_ready !== 1'b1 || we !== 3'b111 || clr !== 3'b111) begin
      fails++;
      $display("FAIL reset_comb in_ready=%b we=%b clr=%b required 1 111 111", in_ready, we, clr);
    end
    in_valid = 1'b1;
    #1;
    tests++;
    if (clr !== 3'b110) begin
      fails++;
      $display("FAIL reset_clr_src clr=%b required 110", clr);
    end
    @(negedge clk);
    resetn = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic test_stream();
    int exp_occ[5] = '{0, 1, 2, 3, 3};
    bit exp_ov[5]  = '{0, 0, 0, 1, 1};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      out_ready = 1'b1;
      in_data = 8'(c + 1);
      #1;
      tests++;
      if (occ !== 2'(exp_occ[c]) || out_valid !== exp_ov[c] || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL stream_c%0d occ=%0d out_valid=%b in_ready=%b required %0d %b 1",
                 c, occ, out_valid, in_ready, exp_occ[c], exp_ov[c]);
      end
      if (exp_ov[c]) begin
        tests++;
        if (d2 !== 8'(c - 2)) begin
          fails++;
          $display("FAIL stream_data_c%0d got %0d required %0d", c, d2, c - 2);
        end
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      out_ready = 1'b0;
      in_data = 8'(11 + c);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      in_data = 8'd14;
      #1;
      tests++;
      if (in_ready !== 1'b0 || we !== 3'b000 || occ !== 2'd3 || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL stall_c%0d in_ready=%b we=%b occ=%0d out_valid=%b required 0 000 3 1",
                 c, in_ready, we, occ, out_valid);
      end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_data = 8'(14 + c);
      #1;
      tests++;
      if (occ !== 2'd3 || in_ready !== 1'b1 || we !== 3'b111 || d2 !== 8'(11 + c)) begin
        fails++;
        $display("FAIL full_flow_c%0d occ=%0d in_ready=%b we=%b data=%0d required 3 1 111 %0d",
                 c, occ, in_ready, we, d2, 11 + c);
      end
    end
    drain();
  endtask

  task automatic test_bubble();
    logic seq_iv[5] = '{1, 0, 0, 1, 0};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = seq_iv[c];
      in_data = (c == 0) ? 8'd21 : 8'd22;
      #1;
      if (c == 3) begin
        tests++;
        if (we !== 3'b011 || clr !== 3'b010 || in_ready !== 1'b1) begin
          fails++;
          $display("FAIL bubble_load we=%b clr=%b in_ready=%b required 011 010 1", we, clr, in_ready);
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    tests++;
    if (we !== 3'b001 || in_ready !== 1'b1 || occ !== 2'd2 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL bubble_collapse we=%b in_ready=%b occ=%0d out_valid=%b required 001 1 2 1",
               we, in_ready, occ, out_valid);
    end
    tests++;
    if (d2 !== 8'd21 || d1 !== 8'd22 || d0 !== 8'd0) begin
      fails++;
      $display("FAIL bubble_data d2=%0d d1=%0d d0=%0d required 21 22 0", d2, d1, d0);
    end
    drain();
  endtask

  task automatic test_flush();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      out_ready = 1'b0;
      in_data = 8'(31 + c);
    end
    @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_data = 8'd33;
    #1;
    tests++;
    if (we !== 3'b111 || clr !== 3'b111 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_cycle we=%b clr=%b in_ready=%b out_valid=%b required 111 111 0 0",
               we, clr, in_ready, out_valid);
    end
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    tests++;
    if (occ !== 2'd0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_after occ=%0d busy=%b out_valid=%b required 0 0 0", occ, busy, out_valid);
    end
    tests++;
    if (d0 !== 8'd0 || d1 !== 8'd0 || d2 !== 8'd0) begin
      fails++;
      $display("FAIL flush_data d0=%0d d1=%0d d2=%0d required 0 0 0", d0, d1, d2);
    end
  endtask

  task automatic test_alternate();
    logic seq_iv[8] = '{1, 0, 1, 0, 1, 0, 0, 0};
    logic exp_ov[8] = '{0, 0, 0, 1, 0, 1, 0, 1};
    int   exp_d[8]  = '{0, 0, 0, 41, 0, 42, 0, 43};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = seq_iv[c];
      in_data = 8'(41 + c / 2);
      #1;
      tests++;
      if (out_valid !== exp_ov[c] || (exp_ov[c] && d2 !== 8'(exp_d[c]))) begin
        fails++;
        $display("FAIL alt_c%0d out_valid=%b data=%0d required %b %0d", c, out_valid, d2, exp_ov[c], exp_d[c]);
      end
      if (c == 1) begin
        tests++;
        if (clr !== 3'b101) begin
          fails++;
          $display("FAIL alt_clr clr=%b required 101", clr);
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    tests++;
    if (occ !== 2'd0) begin
      fails++;
      $display("FAIL alt_empty occ=%0d required 0", occ);
    end
  endtask

  task automatic test_reset_mid();
    int lat = -1;
    logic seq_iv[4] = '{1, 0, 1, 0};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = seq_iv[c];
      in_data = (c == 0) ? 8'd51 : 8'd52;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    tests++;
    if (occ !== 2'd2 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL midrst_pre occ=%0d out_valid=%b required 2 1", occ, out_valid);
    end
    #1;
    resetn = 1'b0;
    #1;
    tests++;
    if (occ !== 2'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midrst_now occ=%0d out_valid=%b busy=%b required 0 0 0", occ, out_valid, busy);
    end
    @(negedge clk);
    resetn = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_data = 8'd61;
    for (int k = 0; k < 10 && lat < 0; k++) begin
      if (k > 0) begin
        @(negedge clk);
        in_data = 8'(61 + k);
      end
      #1;
      if (out_valid) lat = k;
    end
    tests++;
    if (lat != 3 || d2 !== 8'd61) begin
      fails++;
      $display("FAIL midrst_latency lat=%0d data=%0d required 3 61", lat, d2);
    end
    drain();
  endtask

  initial begin
    resetn = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = 8'd0;
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush();
    test_alternate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
